// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller and its arbiters.
package irq_pkg;

  localparam int DEF_N_SRC      = 8;
  localparam int DEF_NEST_DEPTH = 2;
  localparam int STATUS_IE_BIT  = 0;

  // Width of a source ID; kept at least one bit so a 2-source build still has a real field.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder; reusable by any fixed-priority arbiter.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller: latches/level-tracks requests, picks the
// highest-priority eligible source and manages a small stack of active handler IDs.
// The handler "FSM" is implicit in depth: 0 is idle, k>0 means k nested handlers.
module irq_nest_ctrl
  import irq_pkg::*;
#(
  parameter int               N_SRC      = DEF_N_SRC,
  parameter int               NEST_DEPTH = DEF_NEST_DEPTH,
  parameter logic [N_SRC-1:0] EDGE_SRC   = '0,
  localparam int              ID_W       = id_w(N_SRC),
  localparam int              DEP_W      = $clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] intmask,
  input  logic             status_ie,
  input  logic             ex_valid,
  input  logic             eret,
  output logic             take_irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] scause,
  output logic [DEP_W-1:0] depth,
  output logic             in_exception,
  output logic [N_SRC-1:0] pend,
  output logic             err_underflow
);

  logic [N_SRC-1:0] prev_q, pend_q, pend_d;
  logic [N_SRC-1:0] pend_v, elig, set_v, clr_v;
  logic [ID_W-1:0]  sel, top_id;
  logic             any;
  logic [ID_W-1:0]  stack_q [NEST_DEPTH];
  logic [DEP_W-1:0] depth_q, depth_d;
  logic             take_q, take_d;
  logic             err_q, err_d;
  logic             can_nest, pop;

  // Edge sources come from the latched bits, level sources straight from the line.
  assign pend_v = (pend_q & EDGE_SRC) | (irq_src & ~EDGE_SRC);
  assign elig   = pend_v & ~intmask;

  prio_enc #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_sel (
    .req_i (elig),
    .idx_o (sel),
    .any_o (any)
  );

  // Top-of-stack ID; reads 0 when no handler is active.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (depth_q == DEP_W'(i + 1)) top_id = stack_q[i];
    end
  end

  // Take decision, depth bookkeeping and edge-pending update; eret always beats a take.
  always_comb begin
    can_nest = (depth_q == '0) ||
               ((depth_q < DEP_W'(NEST_DEPTH)) && (sel < top_id));
    take_d   = status_ie && ex_valid && any && !eret && can_nest;
    pop      = eret && (depth_q != '0);
    err_d    = err_q | (eret && (depth_q == '0));
    depth_d  = depth_q;
    if (take_d)   depth_d = depth_q + DEP_W'(1);
    else if (pop) depth_d = depth_q - DEP_W'(1);
    // A new edge in the take cycle must survive the clear, so set is applied last.
    set_v    = irq_src & ~prev_q & EDGE_SRC;
    clr_v    = take_d ? (N_SRC'(1) << sel) : '0;
    pend_d   = ((pend_q & ~clr_v) | set_v) & EDGE_SRC;
  end

  // Controller state; the asynchronous reset keeps take_irq low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      pend_q  <= '0;
      depth_q <= '0;
      take_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      prev_q  <= irq_src;
      pend_q  <= pend_d;
      depth_q <= depth_d;
      take_q  <= take_d;
      err_q   <= err_d;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (take_d && (depth_q == DEP_W'(i))) stack_q[i] <= sel;
      end
    end
  end

  assign take_irq      = take_q;
  assign irq_id        = top_id;
  assign depth         = depth_q;
  assign in_exception  = (depth_q != '0);
  assign scause        = (depth_q != '0) ? (N_SRC'(1) << top_id) : '0;
  assign pend          = pend_v;
  assign err_underflow = err_q;

endmodule
